fix_query_arbiter: RTL
======================

Name: fix_query_arbiter

Overview:
- Shares the single lookup port of fix_parser_top among N_REQ independent requesters.
- Lookup port signals: find_tag_i, message_num_i, read_message_i, output_value_o, output_value_valid_o.
- Arbitrates pending queries round-robin, issues exactly one read_message pulse per query, and waits for the parser's valid or a timeout.
- Returns the value, plus a hit/miss flag, to the granted requester. Sits between downstream consumers (order book, risk checks) and the parser's tag/value store.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 64, WAIT-state cycles before declaring a miss (>=2).
- TAG_W, 32, tag width (ASCII tag digits, e.g. 0x3130 = "10").
- MSG_W, 10, message number width.
- VAL_W, 256, value width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_i  in  N_REQ  per-requester query request, level.
- req_tag_i  in  N_REQ*TAG_W  flattened tags; requester k at [k*TAG_W +: TAG_W].
- req_msg_i  in  N_REQ*MSG_W  flattened message numbers; same indexing.
- req_ack_o  out  N_REQ  one-hot; one-cycle pulse when the query is accepted.
- rsp_valid_o  out  N_REQ  one-hot; one-cycle response strobe.
- rsp_hit_o  out  1  1 = parser returned a value, 0 = timeout; valid with rsp_valid_o.
- rsp_value_o  out  VAL_W  returned value; zero on miss.
- find_tag_o  out  TAG_W  to parser find_tag_i.
- message_num_o  out  MSG_W  to parser message_num_i.
- read_message_o  out  1  to parser read_message_i; one-cycle pulse.
- output_value_i  in  VAL_W  from parser output_value_o.
- output_value_valid_i  in  1  from parser output_value_valid_o.
- busy_o  out  1  high in any state except IDLE.
- miss_count_o  out  16  saturating count of timeouts.

Behaviour:
- All outputs are registered. Reset clears every output to 0, sets state to IDLE, round-robin pointer to 0, timer to 0 and miss_count_o to 0.
- Reset asserted mid-query aborts the query without a response. Any late output_value_valid_i is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_i bit is set, grant the first set bit at or after ptr, scanning upward with wrap.
  - Latch that requester's tag and message number into find_tag_o / message_num_o, then go to ISSUE.
  - output_value_valid_i is ignored in IDLE.
- ISSUE (exactly 1 cycle):
  - read_message_o=1 and req_ack_o[k]=1.
  - find_tag_o / message_num_o are stable from this cycle until RESP ends.
  - output_value_valid_i in this cycle is ignored as stale.
  - Timer is cleared; go to WAIT.
- Requester contract: hold req_i and its fields until it sees ack. Deassertion before ack withdraws the request with no response.
- WAIT:
  - If output_value_valid_i=1, capture output_value_i, set hit=1 and go to RESP.
  - Else if timer==TIMEOUT_CYCLES-1, set value=0 and hit=0, increment miss_count_o (saturating at 0xFFFF) and go to RESP.
  - Otherwise increment the timer.
  - If valid and timeout coincide, the hit wins.
- RESP (1 cycle):
  - rsp_valid_o[k]=1 with rsp_hit_o / rsp_value_o.
  - ptr <= (k+1) mod N_REQ; go to IDLE.
  - rsp_value_o and rsp_hit_o hold their value until the next RESP.
- Latency from req sampled in IDLE at edge T:
  - ISSUE cycle T+1.
  - If valid arrives in WAIT cycle T+1+n (n>=1), rsp_valid in cycle T+2+n.
  - Timeout response arrives in cycle T+2+TIMEOUT_CYCLES.
- Only one query is outstanding at a time. Back-to-back queries incur one IDLE cycle between RESP and the next ISSUE.
- Fairness: a continuously requesting port waits at most N_REQ-1 other queries.

Test Plan:
1. Single query after reset: req_i=4'b0100, tag 0x3130, msg 0; parser model asserts valid with value 0x313238 in the 2nd WAIT cycle.
   -> req_ack_o=4'b0100 and read_message_o=1 for exactly one cycle; find_tag_o=0x3130 held; rsp_valid_o=4'b0100 three cycles after ISSUE; rsp_hit_o=1; rsp_value_o=0x313238.
2. All four requesters held high from reset, model responds immediately.
   -> grant order 0,1,2,3,0,1,...; each rsp_valid_o bit pulses once per round; busy_o drops for exactly one cycle between queries.
3. Timeout with TIMEOUT_CYCLES=64: model never asserts valid.
   -> rsp_valid arrives 65 cycles after ISSUE with rsp_hit_o=0 and rsp_value_o=0; miss_count_o=1.
4. Coincident events: valid asserted in the WAIT cycle where timer=63.
   -> rsp_hit_o=1 with the captured value; miss_count_o unchanged.
5. Reset pulse during WAIT of port 1's query, then the model asserts valid, then req_i=4'b0011.
   -> no rsp_valid_o for the aborted query; all outputs 0 after reset; next grant goes to port 0.
6. Spurious traffic: output_value_valid_i pulsed in IDLE and in the ISSUE cycle.
   -> no state change and no capture; the following real valid is captured correctly.

Source files
------------

// File: rtl/fix_query_arbiter.sv
// Round-robin arbiter that shares the parser's single lookup port among N_REQ requesters.
// One query is in flight at a time; each query ends with a value (hit) or a timeout (miss).
module fix_query_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TAG_W          = 32,
  parameter int MSG_W          = 10,
  parameter int VAL_W          = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*TAG_W-1:0] req_tag_i,
  input  logic [N_REQ*MSG_W-1:0] req_msg_i,
  output logic [N_REQ-1:0]       req_ack_o,
  output logic [N_REQ-1:0]       rsp_valid_o,
  output logic                   rsp_hit_o,
  output logic [VAL_W-1:0]       rsp_value_o,
  output logic [TAG_W-1:0]       find_tag_o,
  output logic [MSG_W-1:0]       message_num_o,
  output logic                   read_message_o,
  input  logic [VAL_W-1:0]       output_value_i,
  input  logic                   output_value_valid_i,
  output logic                   busy_o,
  output logic [15:0]            miss_count_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gnt_q, gnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [N_REQ-1:0]   ack_d;
  logic [N_REQ-1:0]   rsp_valid_d;
  logic               hit_d;
  logic [VAL_W-1:0]   value_d;
  logic [TAG_W-1:0]   tag_d;
  logic [MSG_W-1:0]   msg_d;
  logic               read_d;
  logic               busy_d;
  logic [15:0]        miss_d;

  logic               arb_found;
  logic [PTR_W-1:0]   arb_sel;
  logic [PTR_W-1:0]   arb_cand;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= N_REQ) sum = sum - N_REQ;
    return sum[PTR_W-1:0];
  endfunction

  // First requester at or after the round-robin pointer, scanning upward with wrap.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      arb_cand = wrap_add(ptr_q, i);
      if (!arb_found && req_i[arb_cand]) begin
        arb_found = 1'b1;
        arb_sel   = arb_cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    timer_d     = timer_q;
    ack_d       = '0;
    rsp_valid_d = '0;
    hit_d       = rsp_hit_o;
    value_d     = rsp_value_o;
    tag_d       = find_tag_o;
    msg_d       = message_num_o;
    read_d      = 1'b0;
    miss_d      = miss_count_o;

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          gnt_d          = arb_sel;
          tag_d          = req_tag_i[arb_sel*TAG_W +: TAG_W];
          msg_d          = req_msg_i[arb_sel*MSG_W +: MSG_W];
          read_d         = 1'b1;
          ack_d[arb_sel] = 1'b1;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      // A valid in the same cycle as the timeout still counts as a hit.
      WAIT: begin
        if (output_value_valid_i) begin
          value_d            = output_value_i;
          hit_d              = 1'b1;
          rsp_valid_d[gnt_q] = 1'b1;
          state_d            = RESP;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          value_d            = '0;
          hit_d              = 1'b0;
          rsp_valid_d[gnt_q] = 1'b1;
          if (miss_count_o != 16'hFFFF) miss_d = miss_count_o + 16'd1;
          state_d            = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        ptr_d   = wrap_add(gnt_q, 1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      gnt_q          <= '0;
      timer_q        <= '0;
      req_ack_o      <= '0;
      rsp_valid_o    <= '0;
      rsp_hit_o      <= 1'b0;
      rsp_value_o    <= '0;
      find_tag_o     <= '0;
      message_num_o  <= '0;
      read_message_o <= 1'b0;
      busy_o         <= 1'b0;
      miss_count_o   <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gnt_q          <= gnt_d;
      timer_q        <= timer_d;
      req_ack_o      <= ack_d;
      rsp_valid_o    <= rsp_valid_d;
      rsp_hit_o      <= hit_d;
      rsp_value_o    <= value_d;
      find_tag_o     <= tag_d;
      message_num_o  <= msg_d;
      read_message_o <= read_d;
      busy_o         <= busy_d;
      miss_count_o   <= miss_d;
    end
  end

endmodule
